// File: rtl/hyper_mem_test.sv
// HyperRAM fill/readback tester for the hyper_xface user port.
// Writes an LFSR pattern dword by dword, then bursts it back and compares.
module hyper_mem_test #(
  parameter logic [31:0] ADDR_BASE     = 32'h0000_0000,
  parameter int          NUM_WORDS     = 256,
  parameter int          RD_BURST      = 8,
  parameter logic [31:0] SEED          = 32'hACE1_0001,
  parameter logic [7:0]  LATENCY_1X    = 8'h12,
  parameter logic [7:0]  LATENCY_2X    = 8'h16,
  parameter int          TIMEOUT       = 4096,
  parameter int          LED_RUN_BITS  = 22,
  parameter int          LED_FAIL_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        rd_req,
  output logic        wr_req,
  output logic        mem_or_reg,
  output logic [3:0]  wr_byte_en,
  output logic [5:0]  rd_num_dwords,
  output logic [31:0] addr,
  output logic [31:0] wr_d,
  input  logic [31:0] rd_d,
  input  logic        rd_rdy,
  input  logic        busy,
  output logic [7:0]  latency_1x,
  output logic [7:0]  latency_2x,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr,
  output logic        led
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [16:0] NW = 17'(NUM_WORDS);
  localparam logic [5:0] RB = 6'(RD_BURST);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_DATA, S_DONE
  } state_t;

  state_t r_state;
  logic [16:0] r_idx;
  logic [5:0] r_beat;
  logic [31:0] r_lfsr;
  logic [TW-1:0] r_tcnt;
  logic r_first;
  logic r_rd_req, r_wr_req;
  logic [31:0] r_addr, r_wr_d;
  logic r_done, r_pass, r_timeout;
  logic [15:0] r_err;
  logic [31:0] r_first_err;
  logic r_led;
  logic [LED_RUN_BITS-1:0] r_blink;

  logic [31:0] w_addr, w_err_addr, w_lfsr_nx;
  logic [16:0] w_err_idx, w_idx_nx;
  logic w_go, w_tmo, w_accept, w_led_run, w_led_fail;

  assign w_lfsr_nx = {r_lfsr[30:0],
                      r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
  assign w_addr = ADDR_BASE + {13'd0, r_idx, 2'b00};
  assign w_err_idx = r_idx + {11'd0, r_beat};
  assign w_err_addr = ADDR_BASE + {13'd0, w_err_idx, 2'b00};
  assign w_idx_nx = r_idx + {11'd0, RB};
  assign w_go = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_tmo = (r_tcnt == TMAX);
  assign w_accept = rd_rdy && (r_beat < RB);
  assign w_led_run = &r_blink;
  assign w_led_fail = &r_blink[LED_FAIL_BITS-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_beat      <= '0;
      r_lfsr      <= SEED_EFF;
      r_tcnt      <= '0;
      r_first     <= 1'b0;
      r_rd_req    <= 1'b0;
      r_wr_req    <= 1'b0;
      r_addr      <= '0;
      r_wr_d      <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err       <= '0;
      r_first_err <= '0;
    end else begin
      r_rd_req <= 1'b0;
      r_wr_req <= 1'b0;
      if (w_go) begin
        r_idx       <= '0;
        r_lfsr      <= SEED_EFF;
        r_err       <= '0;
        r_first_err <= '0;
        r_done      <= 1'b0;
        r_pass      <= 1'b0;
        r_timeout   <= 1'b0;
        r_state     <= S_WR_REQ;
      end else begin
        unique case (r_state)
          S_WR_REQ: begin
            if (!busy) begin
              r_wr_req <= 1'b1;
              r_addr   <= w_addr;
              r_wr_d   <= r_lfsr;
              r_tcnt   <= '0;
              r_first  <= 1'b1;
              r_state  <= S_WR_WAIT;
            end
          end
          S_WR_WAIT: begin
            r_first <= 1'b0;
            if (!r_first && !busy) begin
              if (r_idx == NW - 17'd1) begin
                r_idx   <= '0;
                r_lfsr  <= SEED_EFF;
                r_state <= S_RD_REQ;
              end else begin
                r_idx   <= r_idx + 17'd1;
                r_lfsr  <= w_lfsr_nx;
                r_state <= S_WR_REQ;
              end
            end else if (w_tmo) begin
              r_done    <= 1'b1;
              r_timeout <= 1'b1;
              r_pass    <= 1'b0;
              r_state   <= S_DONE;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
          S_RD_REQ: begin
            if (!busy) begin
              r_rd_req <= 1'b1;
              r_addr   <= w_addr;
              r_beat   <= '0;
              r_tcnt   <= '0;
              r_first  <= 1'b1;
              r_state  <= S_RD_DATA;
            end
          end
          S_RD_DATA: begin
            r_first <= 1'b0;
            if (w_accept) begin
              if (rd_d != r_lfsr) begin
                if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
                if (r_err == 16'd0) r_first_err <= w_err_addr;
              end
              r_lfsr <= w_lfsr_nx;
              r_beat <= r_beat + 6'd1;
            end
            // busy low before the burst is complete counts as a failed request
            if (!r_first && !busy) begin
              if (r_beat == RB) begin
                if (w_idx_nx == NW) begin
                  r_done  <= 1'b1;
                  r_pass  <= (r_err == 16'd0);
                  r_state <= S_DONE;
                end else begin
                  r_idx   <= w_idx_nx;
                  r_state <= S_RD_REQ;
                end
              end else begin
                r_done    <= 1'b1;
                r_timeout <= 1'b1;
                r_pass    <= 1'b0;
                r_state   <= S_DONE;
              end
            end else if (w_tmo) begin
              r_done    <= 1'b1;
              r_timeout <= 1'b1;
              r_pass    <= 1'b0;
              r_state   <= S_DONE;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink <= '0;
      r_led   <= 1'b0;
    end else begin
      r_blink <= r_blink + LED_RUN_BITS'(1);
      unique case (r_state)
        S_IDLE: r_led <= 1'b0;
        S_DONE: begin
          if (r_pass) r_led <= 1'b1;
          else if (w_led_fail) r_led <= ~r_led;
        end
        default: if (w_led_run) r_led <= ~r_led;
      endcase
    end
  end

  assign rd_req         = r_rd_req;
  assign wr_req         = r_wr_req;
  assign addr           = r_addr;
  assign wr_d           = r_wr_d;
  assign done           = r_done;
  assign pass           = r_pass;
  assign timeout        = r_timeout;
  assign err_count      = r_err;
  assign first_err_addr = r_first_err;
  assign led            = r_led;
  assign mem_or_reg     = 1'b0;
  assign wr_byte_en     = 4'hF;
  assign rd_num_dwords  = RB;
  assign latency_1x     = LATENCY_1X;
  assign latency_2x     = LATENCY_2X;

endmodule

// File: tb/tb_hyper_mem_test.sv
// Bench for hyper_mem_test with a behavioural hyper_xface model.
// Scenario table plus directed reset/restart sequences.
module tb_hyper_mem_test;

  localparam int NW  = 16;
  localparam int RB  = 4;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy = 1'b0;
  logic rd_rdy = 1'b0;
  logic [31:0] rd_d = '0;

  logic rd_req, wr_req, mem_or_reg;
  logic [3:0] wr_byte_en;
  logic [5:0] rd_num_dwords;
  logic [31:0] addr, wr_d, first_err_addr;
  logic [7:0] latency_1x, latency_2x;
  logic done, pass, timeout, led;
  logic [15:0] err_count;

  hyper_mem_test #(
    .ADDR_BASE(32'h0), .NUM_WORDS(NW), .RD_BURST(RB), .SEED(32'h0),
    .TIMEOUT(TMO), .LED_RUN_BITS(6), .LED_FAIL_BITS(3)
  ) dut (
    .clk(clk), .reset(rst), .start(start),
    .rd_req(rd_req), .wr_req(wr_req), .mem_or_reg(mem_or_reg),
    .wr_byte_en(wr_byte_en), .rd_num_dwords(rd_num_dwords),
    .addr(addr), .wr_d(wr_d), .rd_d(rd_d), .rd_rdy(rd_rdy),
    .busy(busy), .latency_1x(latency_1x), .latency_2x(latency_2x),
    .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr), .led(led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // xface model, reacting on the falling edge
  logic m_corrupt = 1'b0;
  logic m_hang_en = 1'b0;
  logic clr = 1'b0;
  int m_nbeats = 4;
  int wr_cnt = 0, rd_cnt = 0, m_bcnt = 0, m_beat = 0, t_wr3 = 0;
  logic m_rd_act = 1'b0, m_hang = 1'b0;
  logic [31:0] m_raddr, m_a;
  logic [31:0] mem [16];
  logic [31:0] wr_a_log [32];
  logic [31:0] wr_d_log [32];
  logic [31:0] rd_a_log [8];

  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0; rd_rdy = 1'b0; m_bcnt = 0; m_rd_act = 1'b0;
      m_hang = 1'b0; wr_cnt = 0; rd_cnt = 0;
    end else begin
      if (clr) begin wr_cnt = 0; rd_cnt = 0; end
      rd_rdy = 1'b0;
      if (wr_req) begin
        if (wr_cnt < 32) begin
          wr_a_log[wr_cnt] = addr;
          wr_d_log[wr_cnt] = wr_d;
        end
        wr_cnt++;
        mem[addr[5:2]] = wr_d;
        busy = 1'b1;
        m_bcnt = 4;
        if (m_hang_en && wr_cnt == 3) begin m_hang = 1'b1; t_wr3 = cyc; end
      end else if (rd_req) begin
        if (rd_cnt < 8) rd_a_log[rd_cnt] = addr;
        rd_cnt++;
        m_raddr = addr; m_beat = 0; m_rd_act = 1'b1; busy = 1'b1;
      end else if (m_rd_act) begin
        if (m_beat < m_nbeats) begin
          m_a = m_raddr + 32'(4 * m_beat);
          rd_d = mem[m_a[5:2]];
          if (m_corrupt && m_a == 32'h24) rd_d[0] = ~rd_d[0];
          rd_rdy = 1'b1;
          m_beat++;
        end else begin
          busy = 1'b0; m_rd_act = 1'b0;
        end
      end else if (m_bcnt > 0) begin
        m_bcnt--;
        if (m_bcnt == 0 && !m_hang) busy = 1'b0;
      end
    end
  end

  typedef struct {
    bit corrupt; bit hang; int nbeats; bit chk_seq;
    bit exp_pass; bit exp_tmo; int exp_err; logic [31:0] exp_first;
    int exp_wr; int exp_rd;
  } vec_t;
  vec_t vecs [4];

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_nx(input logic [31:0] c);
    return {c[30:0], c[31] ^ c[21] ^ c[1] ^ c[0]};
  endfunction

  task automatic pulse_start(input bit do_clr);
    clr = do_clr; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done(output int t);
    bit seen = 0;
    t = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; t = cyc; break; end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t, tog;
    logic prev;
    logic [31:0] e;
    bit seen;

    vecs[0] = '{1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 0, 32'h0, 16, 4};
    vecs[1] = '{1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1, 32'h24, 16, 4};
    vecs[2] = '{1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b1, 0, 32'h0, 3, 0};
    vecs[3] = '{1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 0, 32'h0, 16, 1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wr_d", wr_d, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_first", first_err_addr, 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("const_mor", 32'(mem_or_reg), 32'd0);
    chk("const_be", 32'(wr_byte_en), 32'hF);
    chk("const_nd", 32'(rd_num_dwords), 32'd4);
    chk("const_l1", 32'(latency_1x), 32'h12);
    chk("const_l2", 32'(latency_2x), 32'h16);

    foreach (vecs[i]) begin
      m_corrupt = vecs[i].corrupt;
      m_hang_en = vecs[i].hang;
      m_nbeats = vecs[i].nbeats;
      do_reset();
      pulse_start(1'b1);
      wait_done(t);
      chk($sformatf("v%0d_pass", i), 32'(pass), 32'(vecs[i].exp_pass));
      chk($sformatf("v%0d_tmo", i), 32'(timeout), 32'(vecs[i].exp_tmo));
      chk($sformatf("v%0d_err", i), 32'(err_count), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_first", i), first_err_addr, vecs[i].exp_first);
      chk($sformatf("v%0d_wrcnt", i), 32'(wr_cnt), 32'(vecs[i].exp_wr));
      chk($sformatf("v%0d_rdcnt", i), 32'(rd_cnt), 32'(vecs[i].exp_rd));
      if (vecs[i].hang)
        chk($sformatf("v%0d_tmo_dist", i), 32'(t - t_wr3), 32'(TMO));
      if (vecs[i].exp_pass) begin
        repeat (2) @(negedge clk);
        chk($sformatf("v%0d_led_on", i), 32'(led), 32'd1);
      end else begin
        prev = led; tog = 0;
        repeat (32) begin
          @(negedge clk);
          if (led !== prev) tog++;
          prev = led;
        end
        chk($sformatf("v%0d_led_blink", i), 32'(tog), 32'd4);
      end
      if (vecs[i].chk_seq) begin
        e = 32'd1;
        for (int k = 0; k < NW; k++) begin
          chk($sformatf("wr_addr%0d", k), wr_a_log[k], 32'(4 * k));
          chk($sformatf("wr_d%0d", k), wr_d_log[k], e);
          e = lfsr_nx(e);
        end
        for (int k = 0; k < NW / RB; k++)
          chk($sformatf("rd_addr%0d", k), rd_a_log[k], 32'(16 * k));
      end
    end

    // reset in the middle of a read burst
    m_corrupt = 1'b0; m_hang_en = 1'b0; m_nbeats = 4;
    do_reset();
    pulse_start(1'b1);
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rd_cnt >= 1) begin seen = 1; break; end
    end
    chk("rd_started", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_req", 32'(rd_req), 32'd0);
    chk("mid_rst_addr", addr, 32'd0);
    chk("mid_rst_wr_d", wr_d, 32'd0);
    chk("mid_rst_led", 32'(led), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start(1'b1);
    repeat (20) @(negedge clk);
    pulse_start(1'b0);
    wait_done(t);
    chk("after_rst_pass", 32'(pass), 32'd1);
    chk("ign_start_wrcnt", 32'(wr_cnt), 32'd16);
    chk("ign_start_rdcnt", 32'(rd_cnt), 32'd4);
    chk("seed0_first_wr_d", wr_d_log[0], 32'd1);

    // restart from DONE without reset
    pulse_start(1'b1);
    chk("restart_done_clr", 32'(done), 32'd0);
    wait_done(t);
    chk("rerun_pass", 32'(pass), 32'd1);
    chk("rerun_wrcnt", 32'(wr_cnt), 32'd16);
    e = 32'd1;
    for (int k = 0; k < NW; k++) begin
      chk($sformatf("rerun_wr_d%0d", k), wr_d_log[k], e);
      e = lfsr_nx(e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hyper_mem_test.md
Name: hyper_mem_test

Overview:
- Request-side traffic generator and checker that drives the user port of hyper_xface.
- Fills a HyperRAM region with a 32-bit LFSR pattern using single-dword writes.
- Reads the region back in bursts, regenerates the pattern and compares each dword.
- Reports pass/fail, error count, first failing address and a status LED; it replaces the constant LED drive in the FPGA top level.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address of the first tested dword.
- NUM_WORDS, 256, dwords tested; 1..65536; must be a multiple of RD_BURST.
- RD_BURST, 8, dwords per read request; 1..63.
- SEED, 32'hACE1_0001, LFSR seed; a value of 0 is replaced by 1.
- LATENCY_1X, 8'h12, driven constant on latency_1x.
- LATENCY_2X, 8'h16, driven constant on latency_2x.
- TIMEOUT, 4096, maximum clk cycles per request before a timeout failure.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a test pass when idle or done
- rd_req  out  1  read request pulse to hyper_xface
- wr_req  out  1  write request pulse to hyper_xface
- mem_or_reg  out  1  0 = memory space; held 0
- wr_byte_en  out  4  held 4'hF
- rd_num_dwords  out  6  held RD_BURST
- addr  out  32  request byte address
- wr_d  out  32  write data
- rd_d  in  32  read data, valid while rd_rdy is high
- rd_rdy  in  1  one-cycle pulse per returned dword
- busy  in  1  high while hyper_xface executes a request
- latency_1x  out  8  LATENCY_1X
- latency_2x  out  8  LATENCY_2X
- done  out  1  pass complete (sticky until next start)
- pass  out  1  done with zero errors and no timeout
- timeout  out  1  a request exceeded TIMEOUT
- err_count  out  16  compare mismatches, saturating at 16'hFFFF
- first_err_addr  out  32  address of the first mismatch
- led  out  1  status indicator

Behaviour:
- Reset values: rd_req=0, wr_req=0, addr=0, wr_d=0, done=0, pass=0, timeout=0, err_count=0, first_err_addr=0, led=0, state=IDLE.
- Constant outputs (mem_or_reg, wr_byte_en, rd_num_dwords, latency_1x, latency_2x) hold their values through reset.
- Reset mid-operation: the request pulse drops immediately; no state survives.
- LFSR next value: {cur[30:0], cur[31]^cur[21]^cur[1]^cur[0]}.
  - Write phase and read phase each reload SEED at phase start.
  - Each advances exactly once per dword.
- Handshake rules:
  - A request is a one-cycle pulse, issued only when busy=0.
  - The cycle after the pulse, busy is ignored.
  - Completion is the first following cycle with busy=0.
  - The timeout counter clears at each pulse. Reaching TIMEOUT goes to DONE with timeout=1 and pass=0.
- IDLE: wait for start.
  - start: idx=0, lfsr=SEED, err_count=0, first_err_addr=0, done=0, pass=0, timeout=0 → WR_REQ.
- WR_REQ: when busy=0, pulse wr_req with addr=ADDR_BASE+4*idx and wr_d=lfsr → WR_WAIT.
- WR_WAIT: on completion, advance lfsr and increment idx.
  - idx==NUM_WORDS: idx=0, lfsr=SEED → RD_REQ.
  - Otherwise → WR_REQ.
- RD_REQ: when busy=0, pulse rd_req with addr=ADDR_BASE+4*idx; beat=0 → RD_DATA.
- RD_DATA: on each rd_rdy with beat<RD_BURST:
  - compare rd_d against lfsr.
  - On mismatch, increment err_count (saturating).
  - On the first mismatch of the pass, load first_err_addr=ADDR_BASE+4*(idx+beat).
  - Advance lfsr; beat++.
  - rd_rdy pulses beyond RD_BURST are ignored.
- RD_DATA exit: when beat==RD_BURST and busy=0, idx+=RD_BURST.
  - idx==NUM_WORDS → DONE.
  - Otherwise → RD_REQ.
- RD_DATA: busy falls with beat<RD_BURST → DONE with timeout=1.
- DONE: done=1; pass=(err_count==0 && !timeout).
  - start → IDLE-start actions (restart).
  - start in any other state is ignored.
- Address arithmetic: 32-bit modulo 2^32; wrap past 32'hFFFF_FFFC is allowed.
- idx is 17 bits so it can hold the value NUM_WORDS.
- led:
  - IDLE: 0.
  - Running: toggles every 2^22 clk cycles.
  - DONE pass: 1.
  - DONE fail: toggles every 2^20 clk cycles.

Test Plan:
- Ideal xface model (busy 4 cycles, rd_rdy back-to-back), NUM_WORDS=16, RD_BURST=4 → 16 wr_req, 4 rd_req, done=1, pass=1, err_count=0, addr sequence 0,4,…,60.
- Model corrupts the dword at byte address 0x24 (bit 0 flipped) → err_count=1, first_err_addr=32'h24, pass=0, led blinking fast.
- Model holds busy high forever after the 3rd wr_req → timeout=1, done=1, pass=0 exactly TIMEOUT cycles after that pulse.
- Model returns 2 of 4 rd_rdy then drops busy → timeout=1, pass=0.
- Reset asserted during RD_DATA → all outputs at reset values that cycle; a following start completes with pass=1.
- SEED=0 → first wr_d=32'h0000_0001; second start after DONE reruns and produces an identical wr_d sequence.
